ps2_scancode_assembler: RTL and testbench



---
 rtl/ps2_scancode_assembler.sv | 111 +++++++++++
 tb/tb_ps2_scancode_assembler.sv | 261 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/ps2_scancode_assembler.sv
// Folds raw PS/2 set-2 bytes (E0/F0/E1 prefixes) into one {ext, scancode} ROM
// address per key event, and drops controller noise and fake-shift sequences.
module ps2_scancode_assembler #(
  parameter int TIMEOUT_CYCLES = 65536,
  parameter int TW             = 17
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [7:0] rx_data,
  input  logic       rx_strobe,
  output logic [8:0] code,
  output logic       code_valid,
  output logic       code_break,
  output logic       pause_valid
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_EXT,
    S_BRK,
    S_EXT_BRK,
    S_PAUSE
  } state_t;

  localparam logic [TW-1:0] TMO_LAST = TW'(TIMEOUT_CYCLES - 1);

  state_t        state_q, state_d;
  logic [TW-1:0] tmo_q, tmo_d;
  logic [2:0]    pcnt_q, pcnt_d;
  logic [8:0]    code_q, code_d;
  logic          code_valid_q, code_valid_d;
  logic          code_break_q, code_break_d;
  logic          pause_valid_q, pause_valid_d;
  logic          ext, brk;

  assign ext = (state_q == S_EXT) || (state_q == S_EXT_BRK);
  assign brk = (state_q == S_BRK) || (state_q == S_EXT_BRK);

  always_comb begin
    // NOTE: every signal gets a default first so no path through the decode infers a latch.
    state_d       = state_q;
    pcnt_d        = pcnt_q;
    code_d        = code_q;
    code_break_d  = code_break_q;
    code_valid_d  = 1'b0;
    pause_valid_d = 1'b0;
    tmo_d         = (state_q == S_IDLE) ? '0 : tmo_q + 1'b1;

    if (rx_strobe) begin
      // A byte always beats a timeout expiring on the same cycle.
      tmo_d = '0;
      if (state_q == S_PAUSE) begin
        pcnt_d = pcnt_q - 3'd1;
        if (pcnt_q == 3'd1) begin
          state_d       = S_IDLE;
          pause_valid_d = 1'b1;
        end
      end else if (rx_data == 8'hE1) begin
        state_d = S_PAUSE;
        pcnt_d  = 3'd7;
      end else if (rx_data == 8'hE0 && (state_q == S_IDLE || state_q == S_EXT)) begin
        state_d = S_EXT;
      end else if (rx_data == 8'hF0) begin
        state_d = ext ? S_EXT_BRK : S_BRK;
      end else if (rx_data inside {8'hAA, 8'hFA, 8'hFE, 8'hEE}) begin
        state_d = state_q;
      end else if (rx_data inside {8'h00, 8'hFF}) begin
        state_d = S_IDLE;
      end else if (ext && (rx_data inside {8'h12, 8'h59})) begin
        state_d = S_IDLE;
      end else begin
        state_d      = S_IDLE;
        code_d       = {ext, rx_data};
        code_break_d = brk;
        code_valid_d = 1'b1;
      end
    end else if (state_q != S_IDLE && tmo_q == TMO_LAST) begin
      // Abandon a stale prefix (including an unfinished pause) silently.
      state_d = S_IDLE;
      pcnt_d  = 3'd0;
      tmo_d   = '0;
    end
  end

  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignments so all registers see pre-edge values.
    if (reset) begin
      state_q       <= S_IDLE;
      tmo_q         <= '0;
      pcnt_q        <= 3'd0;
      code_q        <= 9'h000;
      code_valid_q  <= 1'b0;
      code_break_q  <= 1'b0;
      pause_valid_q <= 1'b0;
    end else begin
      state_q       <= state_d;
      tmo_q         <= tmo_d;
      pcnt_q        <= pcnt_d;
      code_q        <= code_d;
      code_valid_q  <= code_valid_d;
      code_break_q  <= code_break_d;
      pause_valid_q <= pause_valid_d;
    end
  end

  assign code        = code_q;
  assign code_valid  = code_valid_q;
  assign code_break  = code_break_q;
  assign pause_valid = pause_valid_q;

endmodule

// File: tb/tb_ps2_scancode_assembler.sv
// Scoreboard bench for ps2_scancode_assembler: each test pushes the events it
// expects, and a negedge monitor pops and compares every code_valid pulse.
module tb_ps2_scancode_assembler;

  localparam int T  = 64;
  localparam int TW = 7;

  typedef struct packed {
    logic [8:0] code;
    logic       brk;
  } exp_t;

  logic       clk = 1'b0;
  logic       reset;
  logic [7:0] rx_data;
  logic       rx_strobe;
  logic [8:0] code;
  logic       code_valid;
  logic       code_break;
  logic       pause_valid;

  int   checks   = 0;
  int   failures = 0;
  int   events   = 0;
  int   pauses   = 0;
  exp_t sb[$];

  ps2_scancode_assembler #(.TIMEOUT_CYCLES(T), .TW(TW)) dut (
    .clk        (clk),
    .reset      (reset),
    .rx_data    (rx_data),
    .rx_strobe  (rx_strobe),
    .code       (code),
    .code_valid (code_valid),
    .code_break (code_break),
    .pause_valid(pause_valid)
  );

  always #5 clk = ~clk;

  // Outputs change on posedge; compare them on the following negedge.
  always @(negedge clk) begin
    if (code_valid === 1'b1) begin
      events++;
      checks++;
      if (sb.size() == 0) begin
        failures++;
        $display("FAIL unexpected_event: got code=%h brk=%b, required no event", code, code_break);
      end else begin
        exp_t e;
        e = sb.pop_front();
        if (code !== e.code || code_break !== e.brk) begin
          failures++;
          $display("FAIL event: got code=%h brk=%b, required code=%h brk=%b",
                   code, code_break, e.code, e.brk);
        end
      end
    end
    if (pause_valid === 1'b1) pauses++;
  end

  // All stimulus is applied right after a negedge, so each byte spans one posedge.
  task automatic drive_byte(input logic [7:0] b);
    rx_data   = b;
    rx_strobe = 1'b1;
    @(negedge clk);
  endtask

  task automatic idle(input int n);
    rx_strobe = 1'b0;
    repeat (n) @(negedge clk);
  endtask

  task automatic expect_event(input logic [8:0] c, input logic b);
    exp_t e;
    e.code = c;
    e.brk  = b;
    sb.push_back(e);
  endtask

  task automatic check_drained(input string name);
    idle(4);
    checks++;
    if (sb.size() != 0) begin
      failures++;
      $display("FAIL %s_missing: %0d events outstanding, required 0", name, sb.size());
      sb.delete();
    end
  endtask

  task automatic pulse_reset();
    rx_strobe = 1'b0;
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    idle(3);
    reset = 1'b0;
    checks++;
    if (code !== 9'h000 || code_valid !== 1'b0 || code_break !== 1'b0 || pause_valid !== 1'b0) begin
      failures++;
      $display("FAIL reset_outputs: got code=%h v=%b brk=%b p=%b, required 000 0 0 0",
               code, code_valid, code_break, pause_valid);
    end
    expect_event(9'h01C, 1'b0);
    drive_byte(8'h1C);
    idle(3);
    checks++;
    if (code !== 9'h01C || code_valid !== 1'b0) begin
      failures++;
      $display("FAIL code_hold: got code=%h v=%b, required 01c 0", code, code_valid);
    end
    check_drained("single");
    expect_event(9'h083, 1'b0);
    drive_byte(8'h83);
    check_drained("code_83");
  endtask

  task automatic test_back_to_back();
    int e0;
    e0 = events;
    expect_event(9'h175, 1'b1);
    drive_byte(8'hE0);
    drive_byte(8'hF0);
    drive_byte(8'h75);
    check_drained("ext_break");
    checks++;
    if (events - e0 != 1) begin
      failures++;
      $display("FAIL ext_break_count: got %0d events, required 1", events - e0);
    end
    expect_event(9'h01C, 1'b0);
    expect_event(9'h032, 1'b0);
    expect_event(9'h032, 1'b1);
    expect_event(9'h16B, 1'b0);
    drive_byte(8'h1C);
    drive_byte(8'h32);
    drive_byte(8'hF0);
    drive_byte(8'h32);
    drive_byte(8'hE0);
    drive_byte(8'h6B);
    check_drained("stream");
  endtask

  task automatic test_pause();
    int e0, p0;
    logic [7:0] seq[8] = '{8'hE1, 8'h14, 8'h77, 8'hE1, 8'hF0, 8'h14, 8'hF0, 8'h77};
    e0 = events;
    p0 = pauses;
    for (int i = 0; i < 8; i++) begin
      drive_byte(seq[i]);
      if (i == 6) begin
        checks++;
        if (pause_valid !== 1'b0) begin
          failures++;
          $display("FAIL pause_early: got pause_valid=%b after byte 7, required 0", pause_valid);
        end
      end
    end
    rx_strobe = 1'b0;
    checks++;
    if (pause_valid !== 1'b1) begin
      failures++;
      $display("FAIL pause_pulse: got pause_valid=%b after byte 8, required 1", pause_valid);
    end
    idle(3);
    checks++;
    if (pauses - p0 != 1 || events - e0 != 0) begin
      failures++;
      $display("FAIL pause_count: got pauses=%0d events=%0d, required 1 0", pauses - p0, events - e0);
    end
    expect_event(9'h01C, 1'b0);
    drive_byte(8'h1C);
    check_drained("after_pause");
  endtask

  task automatic test_filter();
    int e0;
    e0 = events;
    expect_event(9'h05A, 1'b0);
    drive_byte(8'hE0);
    drive_byte(8'h12);
    drive_byte(8'hE0);
    drive_byte(8'hF0);
    drive_byte(8'h12);
    drive_byte(8'hAA);
    idle(2);
    drive_byte(8'hFA);
    drive_byte(8'h5A);
    check_drained("filter");
    checks++;
    if (events - e0 != 1) begin
      failures++;
      $display("FAIL filter_count: got %0d events, required 1", events - e0);
    end
    // Noise bytes inside a prefix must keep the prefix alive.
    expect_event(9'h11F, 1'b1);
    drive_byte(8'hE0);
    drive_byte(8'hFE);
    drive_byte(8'hF0);
    drive_byte(8'hEE);
    drive_byte(8'h1F);
    check_drained("noise_hold");
  endtask

  task automatic test_timeout();
    expect_event(9'h06B, 1'b0);
    drive_byte(8'hE0);
    idle(T);
    drive_byte(8'h6B);
    check_drained("timeout_expired");
    expect_event(9'h16B, 1'b0);
    drive_byte(8'hE0);
    idle(T - 1);
    drive_byte(8'h6B);
    check_drained("timeout_race");
    expect_event(9'h01C, 1'b0);
    drive_byte(8'hE1);
    drive_byte(8'h14);
    idle(T + 2);
    drive_byte(8'h1C);
    check_drained("pause_abort");
  endtask

  task automatic test_reset_mid();
    expect_event(9'h029, 1'b0);
    drive_byte(8'hF0);
    pulse_reset();
    checks++;
    if (code !== 9'h000 || code_valid !== 1'b0) begin
      failures++;
      $display("FAIL reset_mid_outputs: got code=%h v=%b, required 000 0", code, code_valid);
    end
    drive_byte(8'h29);
    check_drained("reset_mid");
    expect_event(9'h029, 1'b0);
    drive_byte(8'hF0);
    drive_byte(8'h00);
    drive_byte(8'h29);
    check_drained("error_byte");
  endtask

  initial begin
    reset     = 1'b1;
    rx_data   = 8'h00;
    rx_strobe = 1'b0;
    @(negedge clk);
    test_reset();
    test_back_to_back();
    test_pause();
    test_filter();
    test_timeout();
    test_reset_mid();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
